// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared op encodings, FSM states and parameter checks for the SRAM controller
package sram_ctrl_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_TURN
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic bit params_ok(input int addr_w, input int data_w, input int len_w,
                                     input int rd_cycles, input int wr_cycles, input int turn_cycles);
        return (addr_w >= 1) && (data_w >= 1) && (len_w >= 1) &&
               (rd_cycles >= 1) && (wr_cycles >= 1) && (turn_cycles >= 1);
    endfunction

endpackage

// File: rtl/sram_dq_iobuf.sv
// rtl/sram_dq_iobuf.sv - tristate driver for the bidirectional SRAM data bus
module sram_dq_iobuf #(
    parameter int DATA_W = 10
) (
    input  logic              oe,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] din,
    inout  wire  [DATA_W-1:0] dq
);

    assign dq  = oe ? dout : {DATA_W{1'bz}};
    assign din = dq;

endmodule

// File: rtl/async_sram_ctrl.sv
// rtl/async_sram_ctrl.sv - async SRAM controller with valid/ready requests, burst reads and fill writes
module async_sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 10,
    parameter int LEN_W       = 4,
    parameter int RD_CYCLES   = 2,
    parameter int WR_CYCLES   = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              op_done,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int CNT_W = $clog2(max3(RD_CYCLES, WR_CYCLES, TURN_CYCLES) + 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
    localparam logic [LEN_W:0]   ONE_BEAT  = (LEN_W+1)'(1);

    if (!params_ok(ADDR_W, DATA_W, LEN_W, RD_CYCLES, WR_CYCLES, TURN_CYCLES)) begin : g_bad_params
        $error("async_sram_ctrl: all width and cycle parameters must be at least 1");
    end

    state_t            state;
    logic [1:0]        op_q;
    logic [LEN_W:0]    beats;
    logic [CNT_W-1:0]  wait_cnt;
    logic              dq_oe;
    logic [DATA_W-1:0] dq_out;
    logic [DATA_W-1:0] dq_in;
    logic [DATA_W-1:0] cap_q;
    logic              rd_pend;

    sram_dq_iobuf #(.DATA_W(DATA_W)) u_dq (
        .oe   (dq_oe),
        .dout (dq_out),
        .din  (dq_in),
        .dq   (sram_dq)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_READ;
            beats     <= '0;
            wait_cnt  <= '0;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            cap_q     <= '0;
            rd_pend   <= 1'b0;
            req_ready <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            op_done   <= 1'b0;
            busy      <= 1'b0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
        end else begin
            op_done  <= 1'b0;
            // Sampled word is presented one edge later so rd_data and rd_valid always align.
            rd_pend  <= 1'b0;
            rd_valid <= rd_pend;
            if (rd_pend) begin
                rd_data <= cap_q;
            end

            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        op_q      <= req_op;
                        sram_addr <= req_addr;
                        beats     <= (LEN_W+1)'(req_len) + 1'b1;
                        dq_out    <= req_wdata;
                        wait_cnt  <= '0;
                        sram_ce_n <= 1'b0;
                        if (req_op == OP_WRITE || req_op == OP_FILL) begin
                            state <= ST_WR_SETUP;
                            dq_oe <= 1'b1;
                        end else begin
                            state     <= ST_RD;
                            sram_oe_n <= 1'b0;
                        end
                    end
                end

                ST_RD: begin
                    if (wait_cnt == RD_LAST) begin
                        cap_q    <= dq_in;
                        rd_pend  <= 1'b1;
                        wait_cnt <= '0;
                        if (beats != ONE_BEAT) begin
                            beats     <= beats - 1'b1;
                            sram_addr <= sram_addr + 1'b1;
                        end else begin
                            state     <= ST_TURN;
                            sram_ce_n <= 1'b1;
                            sram_oe_n <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_WR_SETUP: begin
                    state     <= ST_WR_PULSE;
                    sram_we_n <= 1'b0;
                    wait_cnt  <= '0;
                end

                ST_WR_PULSE: begin
                    if (wait_cnt == WR_LAST) begin
                        state     <= ST_WR_HOLD;
                        sram_we_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_WR_HOLD: begin
                    // Address only moves here, after we_n has been high for a full cycle.
                    if (op_q == OP_FILL && beats != ONE_BEAT) begin
                        state     <= ST_WR_SETUP;
                        beats     <= beats - 1'b1;
                        sram_addr <= sram_addr + 1'b1;
                    end else begin
                        state     <= ST_TURN;
                        sram_ce_n <= 1'b1;
                        dq_oe     <= 1'b0;
                        wait_cnt  <= '0;
                    end
                end

                ST_TURN: begin
                    if (wait_cnt == TURN_LAST) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        op_done   <= 1'b1;
                        req_ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_async_sram_ctrl.sv
// tb/tb_async_sram_ctrl.sv - directed vector bench for async_sram_ctrl with an SRAM model and bus monitor
module tb_async_sram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_addr = 8'h00;
    logic [3:0] req_len = 4'h0;
    logic [9:0] req_wdata = 10'h000;
    logic       rd_valid;
    logic [9:0] rd_data;
    logic       op_done;
    logic       busy;
    logic [7:0] sram_addr;
    wire  [9:0] sram_dq;
    logic       sram_ce_n;
    logic       sram_oe_n;
    logic       sram_we_n;

    async_sram_ctrl #(
        .ADDR_W(8), .DATA_W(10), .LEN_W(4),
        .RD_CYCLES(2), .WR_CYCLES(2), .TURN_CYCLES(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .op_done(op_done), .busy(busy),
        .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural async SRAM: drives when selected and output-enabled, latches on we_n rising.
    logic [9:0] mem [256];
    assign sram_dq = (sram_ce_n == 1'b0 && sram_oe_n == 1'b0) ? mem[sram_addr] : 10'bz;
    always @(posedge sram_we_n) begin
        if (sram_ce_n === 1'b0) mem[sram_addr] = sram_dq;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [9:0] data;
        int         len;
    } pulse_t;

    pulse_t     we_q[$];
    logic [9:0] rd_q[$];
    int         rd_cyc_q[$];
    int         oe_low = 0;
    int         done_cnt = 0;
    int         we_falls = 0;
    bit         ctrl_live = 1'b0;

    logic       prev_we = 1'b1;
    logic [7:0] prev_addr = 8'h00;
    logic [9:0] prev_dq = 10'h000;
    pulse_t     cur;

    always @(negedge clk) begin
        check("inv_oe_we_overlap", (sram_oe_n === 1'b0 && sram_we_n === 1'b0), 1'b0);
        check("inv_drive_while_oe", (sram_oe_n === 1'b0 && u_dut.u_dq.oe === 1'b1), 1'b0);
        check("ready_while_busy", (req_ready === 1'b1 && busy === 1'b1), 1'b0);
        if (ctrl_live) check("ctrl_x", $isunknown({sram_ce_n, sram_oe_n, sram_we_n}), 1'b0);

        if (rst_n) begin
            if (sram_we_n === 1'b0) begin
                if (prev_we) begin
                    we_falls++;
                    cur.addr = sram_addr;
                    cur.data = sram_dq;
                    cur.len  = 1;
                    check("setup_addr", sram_addr, prev_addr);
                    check("setup_dq", sram_dq, prev_dq);
                end else begin
                    cur.len++;
                    check("pulse_addr_stable", sram_addr, cur.addr);
                    check("pulse_dq_stable", sram_dq, cur.data);
                end
            end else if (!prev_we) begin
                check("hold_addr", sram_addr, cur.addr);
                check("hold_dq", sram_dq, cur.data);
                we_q.push_back(cur);
            end
            if (rd_valid === 1'b1) begin
                rd_q.push_back(rd_data);
                rd_cyc_q.push_back(cyc);
            end
            if (sram_oe_n === 1'b0) oe_low++;
            if (op_done === 1'b1) done_cnt++;
        end
        prev_we   = sram_we_n;
        prev_addr = sram_addr;
        prev_dq   = sram_dq;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        we_q.delete();
        rd_q.delete();
        rd_cyc_q.delete();
        oe_low   = 0;
        done_cnt = 0;
        we_falls = 0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [3:0] l,
                         input logic [9:0] d, output int n_edge);
        int t;
        t = 0;
        req_op = op; req_addr = a; req_len = l; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && t < 100) begin step(); t++; end
        check("accept_timeout", req_ready, 1'b1);
        n_edge = cyc + 1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (op_done !== 1'b1 && t < 200) begin step(); t++; end
        check("done_timeout", op_done, 1'b1);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [3:0] len;
        logic [9:0] wdata;
        int         exp_pulses;
        int         exp_reads;
        logic [9:0] exp_rdata;
        int         exp_oe_low;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        int t;
        logic [7:0] ea;

        for (int i = 0; i < 256; i++) mem[i] = 10'h000;

        vecs[0] = '{2'b01, 8'hA5, 4'h0, 10'h15A, 1, 0, 10'h000, 0};
        vecs[1] = '{2'b00, 8'hA5, 4'h0, 10'h000, 0, 1, 10'h15A, 2};
        vecs[2] = '{2'b10, 8'hFE, 4'h3, 10'h3FF, 4, 0, 10'h000, 0};
        vecs[3] = '{2'b00, 8'hFE, 4'h3, 10'h000, 0, 4, 10'h3FF, 8};
        vecs[4] = '{2'b01, 8'h10, 4'h5, 10'h2C3, 1, 0, 10'h000, 0};
        vecs[5] = '{2'b11, 8'h10, 4'h0, 10'h000, 0, 1, 10'h2C3, 2};

        // Reset values
        step(); step();
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ctrl", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_op_done", op_done, 1'b0);
        check("rst_rd_data", rd_data, 10'h000);
        check("rst_addr", sram_addr, 8'h00);
        check("rst_dq_released", u_dut.u_dq.oe, 1'b0);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", req_ready, 1'b1);
        ctrl_live = 1'b1;

        for (int v = 0; v < 6; v++) begin
            clear_logs();
            issue(vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].wdata, n);
            wait_done();
            check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            check($sformatf("v%0d_pulses", v), we_q.size(), vecs[v].exp_pulses);
            for (int i = 0; i < we_q.size() && i < vecs[v].exp_pulses; i++) begin
                ea = vecs[v].addr + 8'(i);
                check($sformatf("v%0d_pulse%0d_addr", v, i), we_q[i].addr, ea);
                check($sformatf("v%0d_pulse%0d_data", v, i), we_q[i].data, vecs[v].wdata);
                check($sformatf("v%0d_pulse%0d_len", v, i), we_q[i].len, 2);
            end
            check($sformatf("v%0d_reads", v), rd_q.size(), vecs[v].exp_reads);
            for (int i = 0; i < rd_q.size() && i < vecs[v].exp_reads; i++) begin
                check($sformatf("v%0d_rd%0d_data", v, i), rd_q[i], vecs[v].exp_rdata);
                check($sformatf("v%0d_rd%0d_cycle", v, i), rd_cyc_q[i] - n, 3 + 2 * i);
            end
            check($sformatf("v%0d_oe_low", v), oe_low, vecs[v].exp_oe_low);
        end

        // req_valid held through a busy write, op switched to read: second op waits for req_ready
        clear_logs();
        req_op = 2'b01; req_addr = 8'h30; req_len = 4'h0; req_wdata = 10'h111; req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 100) begin step(); t++; end
        step();
        req_op = 2'b00;
        t = 0;
        while (!req_ready && t < 100) begin step(); t++; end
        check("hold_ready_back", req_ready, 1'b1);
        check("hold_first_done", done_cnt, 1);
        check("hold_first_pulses", we_q.size(), 1);
        check("hold_no_early_read", rd_q.size(), 0);
        step();
        req_valid = 1'b0;
        wait_done();
        step(); step(); step();
        check("hold_total_done", done_cnt, 2);
        check("hold_total_pulses", we_q.size(), 1);
        check("hold_reads", rd_q.size(), 1);
        if (rd_q.size() > 0) check("hold_rd_data", rd_q[0], 10'h111);

        // Reset asserted during the second write pulse of a fill
        clear_logs();
        issue(2'b10, 8'hFE, 4'h3, 10'h0AA, n);
        t = 0;
        while (!(we_falls == 2 && sram_we_n == 1'b0) && t < 100) begin step(); t++; end
        check("mid_reset_reached", we_falls, 2);
        rst_n = 1'b0;
        step();
        check("mid_rst_ctrl", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("mid_rst_dq_released", u_dut.u_dq.oe, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_op_done", op_done, 1'b0);
        check("mid_rst_rd_valid", rd_valid, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_busy_after", busy, 1'b0);
        check("mid_rst_mem00", mem[8'h00], 10'h3FF);
        check("mid_rst_memFE", mem[8'hFE], 10'h0AA);

        clear_logs();
        issue(2'b00, 8'h00, 4'h0, 10'h000, n);
        wait_done();
        check("post_rst_reads", rd_q.size(), 1);
        if (rd_q.size() > 0) check("post_rst_rd_data", rd_q[0], 10'h3FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
